// File: rtl/matrix_load_ctrl.sv
// Streams matrices A and B into BRAM, starts the systolic array, then drains
// result C from BRAM onto an output stream with a one-word output register.
module matrix_load_ctrl #(
   parameter int unsigned MAX_DIM   = 64,
   parameter int unsigned data_size = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          matrix_size,
   input  logic                 start,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [data_size-1:0] s_data,
   output logic                 wready_q,
   output logic [31:0]          write_addr,
   output logic [data_size-1:0] hello_world_q,
   output logic                 A_cho,
   output logic                 B_cho,
   output logic                 work,
   output logic                 go,
   input  logic                 finish,
   output logic                 arvalid,
   output logic [31:0]          read_addr,
   input  logic [data_size-1:0] ram_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [data_size-1:0] m_data,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int unsigned DW = $clog2(MAX_DIM + 1);
   localparam int unsigned CW = $clog2(MAX_DIM * MAX_DIM + 1);

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, WAIT, DRAIN} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, total;
   logic          rd_pend, wr_a;
   logic          size_ok, last, load, beat, accept;

   assign size_ok = (matrix_size != '0) && (matrix_size <= MAX_DIM);
   assign last    = (cnt == total - CW'(1));
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      load      = (state == LOAD_A) || (state == LOAD_B);
      s_ready   = load;
      beat      = s_valid && load;
      accept    = m_valid && m_ready;
      arvalid   = 1'b0;
      read_addr = '0;
      go        = 1'b0;
      work      = 1'b0;
      done      = 1'b0;
      A_cho     = 1'b0;
      B_cho     = 1'b0;
      case (state)
         IDLE:   if (start && size_ok) state_nx = LOAD_A;
         LOAD_A: begin
            A_cho = 1'b1;
            if (beat && last) state_nx = LOAD_B;
         end
         LOAD_B: begin
            B_cho = 1'b1;
            if (beat && last) state_nx = RUN;
         end
         RUN: begin
            go       = 1'b1;
            work     = 1'b1;
            state_nx = WAIT;
         end
         WAIT: begin
            work = 1'b1;
            if (finish) state_nx = DRAIN;
         end
         DRAIN: begin
            A_cho     = 1'b1;
            read_addr = 32'(cnt);
            // only one word in flight: either a pending read or the output register
            arvalid   = !rd_pend && (cnt < total) && (!m_valid || m_ready);
            if (accept && (cnt == total)) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      // a registered write trails its beat by one cycle, so it carries its own bank
      if (wready_q) begin
         A_cho = wr_a;
         B_cho = !wr_a;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt           <= '0;
         total         <= '0;
         rd_pend       <= 1'b0;
         wr_a          <= 1'b0;
         wready_q      <= 1'b0;
         write_addr    <= '0;
         hello_world_q <= '0;
         m_valid       <= 1'b0;
         m_data        <= '0;
         err           <= 1'b0;
      end else begin
         err      <= (state == IDLE) && start && !size_ok;
         wready_q <= beat;
         rd_pend  <= arvalid;
         if (beat) begin
            write_addr    <= 32'(cnt);
            hello_world_q <= s_data;
            wr_a          <= (state == LOAD_A);
         end
         if ((state == IDLE) && start && size_ok) begin
            cnt   <= '0;
            total <= CW'(matrix_size[DW-1:0]) * CW'(matrix_size[DW-1:0]);
         end else if (beat) begin
            cnt <= last ? '0 : cnt + CW'(1);
         end else if (arvalid) begin
            cnt <= cnt + CW'(1);
         end
         if (rd_pend) begin
            m_valid <= 1'b1;
            m_data  <= ram_data;
         end else if (accept) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Bench for matrix_load_ctrl: BRAM/array environment plus expected write,
// read and result sequences built from the job parameters.
module tb_matrix_load_ctrl;

   localparam int unsigned MAX_DIM = 8;
   localparam int unsigned DS      = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   matrix_size;
   logic          start, s_valid, s_ready;
   logic [DS-1:0] s_data;
   logic          wready_q;
   logic [31:0]   write_addr;
   logic [DS-1:0] hello_world_q;
   logic          A_cho, B_cho, work, go, finish, arvalid;
   logic [31:0]   read_addr;
   logic [DS-1:0] ram_data = '0;
   logic          m_valid, m_ready;
   logic [DS-1:0] m_data;
   logic          busy, done, err;

   matrix_load_ctrl #(.MAX_DIM(MAX_DIM), .data_size(DS)) dut (
      .clk(clk), .reset(reset), .matrix_size(matrix_size), .start(start),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .wready_q(wready_q), .write_addr(write_addr), .hello_world_q(hello_world_q),
      .A_cho(A_cho), .B_cho(B_cho), .work(work), .go(go), .finish(finish),
      .arvalid(arvalid), .read_addr(read_addr), .ram_data(ram_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   // result matrix C as preloaded in BRAM; one-cycle read latency
   logic [DS-1:0] c_mem [MAX_DIM*MAX_DIM];
   always @(posedge clk)
      if (arvalid) ram_data <= (read_addr < MAX_DIM*MAX_DIM) ? c_mem[read_addr] : 'x;

   logic [1:0]    wr_bank_q[$];
   logic [31:0]   wr_addr_q[$];
   logic [DS-1:0] wr_data_q[$];
   logic [31:0]   rd_q[$];
   logic [DS-1:0] acc_q[$];
   int go_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cyc = 0, strobe_cyc = 0;

   always @(negedge clk) begin
      if (wready_q) begin
         wr_bank_q.push_back({A_cho, B_cho});
         wr_addr_q.push_back(write_addr);
         wr_data_q.push_back(hello_world_q);
      end
      if (arvalid) rd_q.push_back(read_addr);
      if (m_valid && m_ready) acc_q.push_back(m_data);
      if (go) go_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (busy) busy_cyc++;
      if (wready_q || arvalid || go) strobe_cyc++;
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs_zero(input string tag);
      chk(tag, {s_ready, wready_q, write_addr, hello_world_q, A_cho, B_cho, work, go,
                arvalid, read_addr, m_valid, m_data, busy, done, err}, '0);
   endtask

   // entered and left at posedge+1
   task automatic run_job(input int unsigned n, input bit directed, input int vmode,
                          input bit stall, input bit rnd_ready, input int fin_delay,
                          input bit stray, input bit rst_in_wait);
      int unsigned   nn;
      logic [DS-1:0] w[$];
      int            idx, cyc, g0, d0, e0;
      bit            stalled;
      nn = n * n;
      idx = 0; cyc = 0; stalled = 0;
      wr_bank_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); rd_q.delete(); acc_q.delete();
      for (int i = 0; i < 2*nn; i++) w.push_back(directed ? DS'(i + 1) : $urandom);
      for (int i = 0; i < nn; i++) c_mem[i] = $urandom;
      g0 = go_cnt; d0 = done_cnt; e0 = err_cnt;

      matrix_size = n; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      while (idx < 2*nn && cyc < 8*nn + 20) begin
         s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         s_data  = s_valid ? w[idx] : $urandom;
         start   = stray && (cyc == 2);
         finish  = stray && (cyc == 3);
         if (stray && cyc == 2) matrix_size = 3;
         #1 if (s_valid && s_ready) idx++;
         @(posedge clk); #1 cyc++;
      end
      s_valid = 1'b0; start = 1'b0; finish = 1'b0;
      chk("feed_beats", idx, 2*nn);

      cyc = 0;
      while (go_cnt == g0 && cyc < 10) begin
         @(posedge clk); #1 cyc++;
      end
      chk("go_seen", go_cnt - g0, 1);
      chk("wr_count", wr_addr_q.size(), 2*nn);

      if (rst_in_wait) begin
         repeat (3) @(posedge clk);
         #1 chk("work_in_wait", {busy, work, go}, 3'b110);
         reset = 1'b0;
         #1 chk_outs_zero("rst_wait_outs");
         @(posedge clk); #1 chk_outs_zero("rst_wait_outs_clk");
         reset = 1'b1;
         repeat (3) @(posedge clk);
         #1 chk("rst_no_done", done_cnt - d0, 0);
         chk("rst_no_err", err_cnt - e0, 0);
         chk("rst_idle", busy, 1'b0);
         return;
      end

      repeat (fin_delay) @(posedge clk);
      #1 chk("wait_hold", {busy, work, go, arvalid}, 4'b1100);
      finish = 1'b1;
      @(posedge clk); #1 finish = 1'b0;

      m_ready = 1'b1; cyc = 0;
      while (done_cnt == d0 && cyc < 6*nn + 40) begin
         if (stall && !stalled && acc_q.size() == 2 && m_valid) begin
            m_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               #1 chk("stall_data", m_data, c_mem[2]);
               chk("stall_valid_no_read", {m_valid, arvalid}, 2'b10);
               @(posedge clk); #1 cyc++;
            end
            m_ready = 1'b1; stalled = 1;
         end else begin
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1 cyc++;
         end
      end
      m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("done_once", done_cnt - d0, 1);
      chk("go_once", go_cnt - g0, 1);
      chk("no_err", err_cnt - e0, 0);
      chk("idle_after", {busy, m_valid}, 2'b00);
      if (stall) chk("stall_hit", stalled, 1'b1);

      for (int i = 0; i < 2*nn && i < wr_addr_q.size(); i++) begin
         chk("wr_bank", wr_bank_q[i], (i < nn) ? 2'b10 : 2'b01);
         chk("wr_addr", wr_addr_q[i], (i < nn) ? i : i - nn);
         chk("wr_data", wr_data_q[i], w[i]);
      end
      chk("rd_count", rd_q.size(), nn);
      for (int i = 0; i < nn && i < rd_q.size(); i++) chk("rd_addr", rd_q[i], i);
      chk("acc_count", acc_q.size(), nn);
      for (int i = 0; i < nn && i < acc_q.size(); i++) chk("m_data", acc_q[i], c_mem[i]);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int e0, b0, s0;
      logic [31:0] bad [3];
      reset = 1'b0; matrix_size = '0; start = 0; s_valid = 0; s_data = '0;
      finish = 0; m_ready = 1'b1;
      #2 chk_outs_zero("reset_outs");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      chk_outs_zero("post_reset_outs");

      // directed 2x2 job, continuous stream, finish 10 cycles after go
      run_job(2, 1, 0, 0, 0, 10, 0, 0);

      // bad sizes, including one whose low bits look legal
      bad[0] = 0; bad[1] = MAX_DIM + 1; bad[2] = 32'h8000_0001;
      e0 = err_cnt; b0 = busy_cyc; s0 = strobe_cyc;
      for (int i = 0; i < 3; i++) begin
         matrix_size = bad[i]; start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         repeat (3) @(posedge clk);
         #1 chk("err_pulse", err_cnt - e0, i + 1);
      end
      chk("err_busy", busy_cyc - b0, 0);
      chk("err_strobes", strobe_cyc - s0, 0);

      run_job(3, 0, 1, 0, 0, 4, 0, 0);              // toggled s_valid
      run_job(4, 0, 2, 1, 0, 2, 1, 0);              // stall mid-drain, stray start/finish
      run_job(MAX_DIM, 0, 0, 0, 1, 0, 0, 0);        // largest size, random m_ready
      run_job(5, 0, 2, 1, 1, 1, 0, 0);
      run_job(1, 0, 0, 0, 0, 3, 0, 0);
      run_job(2, 0, 0, 0, 0, 0, 0, 1);              // reset while WAIT
      run_job(1, 0, 0, 0, 0, 2, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
